// File: rtl/gpio_seq_pkg.sv
// Shared types and grgpio register offsets for the GPIO APB sequencer.
package gpio_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RMW   = 2'b10
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WSETUP,
    ST_WACCESS,
    ST_RESP
  } state_e;

  localparam logic [7:0] OFS_DATA      = 8'h00;
  localparam logic [7:0] OFS_OUT       = 8'h04;
  localparam logic [7:0] OFS_DIR       = 8'h08;
  localparam logic [7:0] OFS_IMASK     = 8'h0C;
  localparam logic [7:0] OFS_OR_OUT    = 8'h54;
  localparam logic [7:0] OFS_OR_DIR    = 8'h58;
  localparam logic [7:0] OFS_OR_IMASK  = 8'h5C;
  localparam logic [7:0] OFS_AND_OUT   = 8'h64;
  localparam logic [7:0] OFS_AND_DIR   = 8'h68;
  localparam logic [7:0] OFS_AND_IMASK = 8'h6C;
  localparam logic [7:0] OFS_XOR_OUT   = 8'h74;
  localparam logic [7:0] OFS_XOR_DIR   = 8'h78;
  localparam logic [7:0] OFS_XOR_IMASK = 8'h7C;

  // The reserved encoding 2'b11 behaves as a plain read.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b00:   decode_op = OP_WRITE;
      2'b10:   decode_op = OP_RMW;
      default: decode_op = OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/gpio_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module gpio_rr_arb (
  input  logic clk,
  input  logic rstn,
  input  logic valid_a,
  input  logic valid_b,
  input  logic accept,
  output logic grant_a,
  output logic grant_b
);

  logic last_b;

  always_comb begin
    grant_a = valid_a & (~valid_b | last_b);
    grant_b = valid_b & ~grant_a;
  end

  // Reset to "B granted last" so A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rstn)       last_b <= 1'b1;
    else if (accept) last_b <= grant_b;
  end

endmodule

// File: rtl/gpio_apb_sequencer.sv
// APB master serving two command requesters against one grgpio, with atomic read-modify-write.
//
// state      | meaning
// ST_IDLE    | waiting for a command, ready asserted to the arbitration winner
// ST_SETUP   | APB setup phase (psel=1, penable=0)
// ST_ACCESS  | APB access phase, waiting for pready or timeout
// ST_WSETUP  | RMW write-back setup phase
// ST_WACCESS | RMW write-back access phase
// ST_RESP    | one-cycle response pulse to the command owner
module gpio_apb_sequencer
  import gpio_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DATA_W    = 32,
  parameter int          TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqa_valid,
  output logic              reqa_ready,
  input  logic [1:0]        reqa_op,
  input  logic [7:0]        reqa_addr,
  input  logic [DATA_W-1:0] reqa_wdata,
  input  logic [DATA_W-1:0] reqa_mask,
  output logic              rspa_valid,
  output logic [DATA_W-1:0] rspa_rdata,
  output logic              rspa_err,
  input  logic              reqb_valid,
  output logic              reqb_ready,
  input  logic [1:0]        reqb_op,
  input  logic [7:0]        reqb_addr,
  input  logic [DATA_W-1:0] reqb_wdata,
  input  logic [DATA_W-1:0] reqb_mask,
  output logic              rspb_valid,
  output logic [DATA_W-1:0] rspb_rdata,
  output logic              rspb_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  state_e            state;
  op_e               cmd_op;
  logic              cmd_owner_b;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;
  logic [DATA_W-1:0] old_q;
  logic [TW-1:0]     timer;

  logic              grant_a, grant_b, accept;
  op_e               sel_op;
  logic [7:0]        sel_addr;
  logic [DATA_W-1:0] sel_wdata, sel_mask;
  logic              fin, fin_err, rmw_go;
  logic [DATA_W-1:0] fin_rdata;

  assign accept = (state == ST_IDLE) & (reqa_valid | reqb_valid);

  gpio_rr_arb u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .valid_a (reqa_valid),
    .valid_b (reqb_valid),
    .accept  (accept),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign reqa_ready = (state == ST_IDLE) & grant_a;
  assign reqb_ready = (state == ST_IDLE) & grant_b;

  always_comb begin
    sel_op    = decode_op(grant_a ? reqa_op : reqb_op);
    sel_addr  = grant_a ? reqa_addr  : reqb_addr;
    sel_wdata = grant_a ? reqa_wdata : reqb_wdata;
    sel_mask  = grant_a ? reqa_mask  : reqb_mask;
  end

  // Completion of the current command: pready ends a phase unless it opens the RMW write-back.
  always_comb begin
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    rmw_go    = 1'b0;
    if (state == ST_ACCESS || state == ST_WACCESS) begin
      if (pready) begin
        if (state == ST_ACCESS && cmd_op == OP_RMW && !pslverr) begin
          rmw_go = 1'b1;
        end else begin
          fin     = 1'b1;
          fin_err = pslverr;
          if (state == ST_WACCESS)    fin_rdata = old_q;
          else if (cmd_op != OP_WRITE) fin_rdata = prdata;
        end
      end else if (timer == '0) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cmd_op      <= OP_READ;
      cmd_owner_b <= 1'b0;
      cmd_wdata   <= '0;
      cmd_mask    <= '0;
      old_q       <= '0;
      timer       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rspa_valid  <= 1'b0;
      rspa_rdata  <= '0;
      rspa_err    <= 1'b0;
      rspb_valid  <= 1'b0;
      rspb_rdata  <= '0;
      rspb_err    <= 1'b0;
    end else begin
      rspa_valid <= 1'b0;
      rspb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_op      <= sel_op;
            cmd_owner_b <= grant_b;
            cmd_wdata   <= sel_wdata;
            cmd_mask    <= sel_mask;
            psel        <= 1'b1;
            penable     <= 1'b0;
            pwrite      <= (sel_op == OP_WRITE);
            paddr       <= BASE_ADDR | {24'h0, sel_addr};
            pwdata      <= (sel_op == OP_WRITE) ? sel_wdata : '0;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP, ST_WSETUP: begin
          penable <= 1'b1;
          timer   <= TMR_LOAD;
          state   <= (state == ST_SETUP) ? ST_ACCESS : ST_WACCESS;
        end
        ST_ACCESS, ST_WACCESS: begin
          if (rmw_go) begin
            old_q   <= prdata;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            pwdata  <= (prdata & ~cmd_mask) | (cmd_wdata & cmd_mask);
            state   <= ST_WSETUP;
          end else if (fin) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= ST_RESP;
            if (cmd_owner_b) begin
              rspb_valid <= 1'b1;
              rspb_rdata <= fin_rdata;
              rspb_err   <= fin_err;
            end else begin
              rspa_valid <= 1'b1;
              rspa_rdata <= fin_rdata;
              rspa_err   <= fin_err;
            end
          end else if (!pready) begin
            timer <= timer - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
